// File: rtl/axis_frame_pkg.sv
// Shared types for the AXI-Stream frame indexer.
package axis_frame_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/axis_reg_slice.sv
// One-deep registered valid/ready slice; full throughput when the sink keeps ready high.
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);
  logic [WIDTH-1:0] data_q;
  logic             vld_q;

  assign s_ready_o = !vld_q || m_ready_i;
  assign m_data_o  = data_q;
  assign m_valid_o = vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (s_ready_o) begin
      vld_q <= s_valid_i;
      if (s_valid_i) data_q <= s_data_i;
    end
  end
endmodule

// File: rtl/axis_frame_indexer.sv
// Tags each forwarded sample with its index within a frame and counts frames per run.
// Optional sticky overrun flag: define AXIS_FRAME_INDEXER_OVERRUN_EN.
module axis_frame_indexer
  import axis_frame_pkg::*;
#(
  parameter int TDATA_WIDTH = 16,
  parameter int TUSER_WIDTH = 16,
  parameter int LEN_WIDTH   = 12,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
  input  logic [CNT_WIDTH-1:0]   cfg_frames,
  input  logic                   start,
  input  logic                   stop,
`ifdef AXIS_FRAME_INDEXER_OVERRUN_EN
  output logic                   overrun,
`endif
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   frame_cnt
);
  localparam int SW = TDATA_WIDTH + TUSER_WIDTH + 1;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] idx_q, len_q, idx_nxt;
  logic [CNT_WIDTH-1:0] fcnt_q, frames_q, fcnt_inc;
  logic                 slice_rdy, acc, at_last, run_done, go_run;
  logic [SW-1:0]        slice_in, slice_out;

  assign busy          = (state_q != IDLE);
  assign s_axis_tready = busy ? slice_rdy : 1'b1;
  assign acc           = busy && s_axis_tvalid && slice_rdy;
  assign at_last       = (idx_q == len_q);
  assign idx_nxt       = at_last ? '0 : idx_q + 1'b1;
  assign fcnt_inc      = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;
  assign run_done      = (frames_q != '0) && (fcnt_inc == frames_q);
  assign go_run        = (state_q == IDLE) && start && !stop;
  assign frame_cnt     = fcnt_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      fcnt_q   <= '0;
      frames_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (go_run) begin
          state_q  <= RUN;
          len_q    <= cfg_frame_len;
          frames_q <= cfg_frames;
          idx_q    <= '0;
          fcnt_q   <= '0;
        end
        RUN, DRAIN: begin
          if (acc) begin
            idx_q <= idx_nxt;
            if (at_last) fcnt_q <= fcnt_inc;
          end
          if (acc && at_last && (run_done || state_q == DRAIN))
            state_q <= IDLE;
          // A stop landing on a frame boundary ends the run without a drain phase.
          else if (state_q == RUN && stop)
            state_q <= (((acc ? idx_nxt : idx_q) == '0)) ? IDLE : DRAIN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slice_in = {s_axis_tdata, TUSER_WIDTH'(idx_q), at_last};

  axis_reg_slice #(.WIDTH(SW)) u_out (
    .clk       (aclk),
    .rst       (areset),
    .s_data_i  (slice_in),
    .s_valid_i (busy && s_axis_tvalid),
    .s_ready_o (slice_rdy),
    .m_data_o  (slice_out),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

  assign m_axis_tdata = slice_out[SW-1 -: TDATA_WIDTH];
  assign m_axis_tuser = slice_out[TUSER_WIDTH:1];
  assign m_axis_tlast = slice_out[0];

`ifdef AXIS_FRAME_INDEXER_OVERRUN_EN
  logic overrun_q;
  assign overrun = overrun_q;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                                     overrun_q <= 1'b0;
    else if (go_run)                                overrun_q <= 1'b0;
    else if (busy && s_axis_tvalid && !s_axis_tready) overrun_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_axis_frame_indexer.sv
// Directed bench with a transaction-level scoreboard model for axis_frame_indexer.
module tb_axis_frame_indexer;
  logic        aclk = 0, areset = 1;
  logic [15:0] s_axis_tdata = 0;
  logic        s_axis_tvalid = 0, s_axis_tready;
  logic [15:0] m_axis_tdata, m_axis_tuser;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1;
  logic [11:0] cfg_frame_len = 0;
  logic [15:0] cfg_frames = 0;
  logic        start = 0, stop = 0, busy;
  logic [15:0] frame_cnt;
`ifdef AXIS_FRAME_INDEXER_OVERRUN_EN
  logic        overrun;
`endif

  axis_frame_indexer dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .cfg_frame_len(cfg_frame_len), .cfg_frames(cfg_frames), .start(start), .stop(stop),
`ifdef AXIS_FRAME_INDEXER_OVERRUN_EN
    .overrun(overrun),
`endif
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;

  int checks = 0, fails = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard model: run flag, index, frame count, drain flag, pending output samples.
  typedef struct packed { logic [15:0] d; logic [15:0] u; logic l; } smp_t;
  smp_t        q[$];
  logic [15:0] log_u[$];
  logic        log_l[$];
  bit          m_busy = 0, m_drain = 0, prev_stall = 0;
  int          m_idx = 0, m_len = 0, m_frames = 0, m_fc = 0;
  smp_t        pv, e;

  always @(negedge aclk) begin
    if (areset) begin
      m_busy = 0; m_drain = 0; m_idx = 0; m_fc = 0; prev_stall = 0; q.delete();
    end else begin
      chk("busy", busy, m_busy);
      chk("frame_cnt", frame_cnt, m_fc);
      chk("m_tvalid", m_axis_tvalid, q.size() != 0);
      if (!m_busy) chk("idle_tready", s_axis_tready, 1);
      else if (q.size() == 0 || m_axis_tready) chk("run_tready", s_axis_tready, 1);
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, pv);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pv = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        log_u.push_back(m_axis_tuser);
        log_l.push_back(m_axis_tlast);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_tdata", m_axis_tdata, e.d);
          chk("out_tuser", m_axis_tuser, e.u);
          chk("out_tlast", m_axis_tlast, e.l);
        end
      end
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy = 1; m_drain = 0; m_idx = 0; m_fc = 0;
          m_len = cfg_frame_len; m_frames = cfg_frames;
        end
      end else begin
        if (s_axis_tvalid && s_axis_tready) begin
          q.push_back({s_axis_tdata, 16'(m_idx), m_idx == m_len});
          if (m_idx == m_len) begin
            m_idx = 0;
            if (m_fc != 16'hFFFF) m_fc++;
            if (m_drain || (m_frames != 0 && m_fc == m_frames)) m_busy = 0;
          end else m_idx++;
        end
        if (m_busy && stop && !m_drain) begin
          if (m_idx == 0) m_busy = 0;
          else m_drain = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk); #1;
    s_axis_tdata = s_axis_tdata + 1;
  endtask

  task automatic pulse(input bit st, input bit sp);
    start = st; stop = sp; step(); start = 0; stop = 0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    chk(nm, busy, 0);
  endtask

  task automatic wait_idx(string nm, int k);
    int n = 0;
    while (m_idx != k && n < 100) begin step(); n++; end
    chk(nm, m_idx, k);
  endtask

  task automatic drain();
    m_axis_tready = 1;
    repeat (3) step();
  endtask

  initial begin
    repeat (2) step();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    areset = 0;
    s_axis_tvalid = 1;
    repeat (3) step();
    chk("idle_no_out", log_u.size(), 0);

    // Two frames of eight, then automatic return to idle.
    cfg_frame_len = 7; cfg_frames = 2;
    log_u.delete(); log_l.delete();
    pulse(1, 0);
    wait_idle("t35_timeout");
    chk("t35_fcnt", frame_cnt, 2);
    drain();
    chk("t35_count", log_u.size(), 16);
    if (log_u.size() == 16)
      for (int i = 0; i < 16; i++) begin
        chk("t35_tuser", log_u[i], i % 8);
        chk("t35_tlast", log_l[i], (i % 8) == 7);
      end

    // Stop mid-frame: the frame completes before idle.
    cfg_frame_len = 3; cfg_frames = 0;
    log_u.delete(); log_l.delete();
    pulse(1, 0);
    wait_idx("t36_idx", 2);
    pulse(0, 1);
    wait_idle("t36_timeout");
    drain();
    chk("t36_count", log_u.size(), 4);
    if (log_u.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t36_tuser", log_u[i], i);
        chk("t36_tlast", log_l[i], i == 3);
      end
    chk("t36_fcnt", frame_cnt, 1);

    // Back-pressure toggling 1010...
    cfg_frame_len = 5; cfg_frames = 3;
    log_u.delete(); log_l.delete();
    pulse(1, 0);
    for (int n = 0; n < 300 && busy; n++) begin
      m_axis_tready = ~m_axis_tready;
      step();
    end
    chk("t37_timeout", busy, 0);
    drain();
    chk("t37_count", log_u.size(), 18);
    if (log_u.size() == 18)
      for (int i = 0; i < 18; i++) chk("t37_tuser", log_u[i], i % 6);
    chk("t37_fcnt", frame_cnt, 3);

    // Asynchronous reset mid-frame, then restart from index 0.
    cfg_frame_len = 15; cfg_frames = 0;
    pulse(1, 0);
    wait_idx("t38_idx", 5);
    areset = 1; #1;
    chk("t38_tvalid", m_axis_tvalid, 0);
    chk("t38_tdata", m_axis_tdata, 0);
    chk("t38_tuser", m_axis_tuser, 0);
    chk("t38_tlast", m_axis_tlast, 0);
    chk("t38_busy", busy, 0);
    chk("t38_fcnt", frame_cnt, 0);
    repeat (2) step();
    areset = 0;
    step();
    log_u.delete(); log_l.delete();
    pulse(1, 0);
    for (int n = 0; n < 20 && log_u.size() == 0; n++) step();
    chk("t38_first_seen", log_u.size() != 0, 1);
    if (log_u.size() != 0) chk("t38_first_tuser", log_u[0], 0);
    pulse(0, 1);
    wait_idle("t38_timeout");
    drain();

    // Simultaneous start and stop in idle.
    log_u.delete(); log_l.delete();
    pulse(1, 1);
    repeat (3) step();
    chk("t39_busy", busy, 0);
    chk("t39_no_out", log_u.size(), 0);

`ifdef AXIS_FRAME_INDEXER_OVERRUN_EN
    cfg_frame_len = 7; cfg_frames = 0;
    m_axis_tready = 0;
    pulse(1, 0);
    repeat (3) step();
    chk("t40_set", overrun, 1);
    m_axis_tready = 1;
    pulse(0, 1);
    wait_idle("t40_timeout");
    drain();
    chk("t40_sticky", overrun, 1);
    pulse(1, 0);
    chk("t40_clear", overrun, 0);
    pulse(0, 1);
    wait_idle("t40_timeout2");
    drain();
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
